// File: rtl/codma_mem_responder.sv
// CODMA memory responder: services burst read/write requests against an internal word RAM.
// Optional request statistics counters are enabled by defining CODMA_RESP_STATS_EN.
module codma_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         req_read_i,
  input  logic         req_write_i,
  input  logic [31:0]  req_addr_i,
  input  logic [7:0]   req_size_i,
  input  logic [255:0] wr_data_i,
  output logic [255:0] rd_data_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [15:0]  rd_count_o,
  output logic [15:0]  wr_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StXfer, StDone} state_e;

  state_e         r_state, w_state_d;
  logic           r_rd, r_err;
  logic [AW-1:0]  r_idx;
  logic [2:0]     r_beat, r_last_beat;
  logic [3:0]     r_wcnt;
  logic [255:0]   r_wdata, r_rdata;
  logic [31:0]    r_mem [DEPTH];

  logic           w_accept, w_size_ok, w_req_err, w_last;
  logic [3:0]     w_beats;
  logic [2:0]     w_last_beat;
  logic [31:0]    w_off, w_idx;
  logic [AW-1:0]  w_mem_addr;
  logic [31:0]    w_wword;

  always_comb begin
    w_size_ok   = 1'b1;
    w_beats     = 4'd0;
    w_last_beat = 3'd0;
    case (req_size_i)
      8'd3:    begin w_beats = 4'd2; w_last_beat = 3'd1; end
      8'd8:    begin w_beats = 4'd4; w_last_beat = 3'd3; end
      8'd9:    begin w_beats = 4'd8; w_last_beat = 3'd7; end
      default: w_size_ok = 1'b0;
    endcase
  end

  // BASE_ADDR is word aligned, so alignment of the offset equals alignment of the address.
  assign w_off     = req_addr_i - BASE_ADDR;
  assign w_idx     = {2'b00, w_off[31:2]};
  assign w_req_err = !w_size_ok || (w_off[1:0] != 2'b00) || (req_addr_i < BASE_ADDR) ||
                     ((33'(w_idx) + 33'(w_beats)) > 33'(DEPTH));
  assign w_accept  = (r_state == StIdle) && (req_read_i || req_write_i);
  assign w_last    = (r_beat == r_last_beat);
  assign w_mem_addr = r_idx + AW'(r_beat);
  assign w_wword   = r_wdata[{r_beat, 5'b0} +: 32];

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          // Rejected requests spend one cycle in WAIT so done_o follows edge 1.
          if (w_req_err || (WAIT_CYCLES != 0)) w_state_d = StWait;
          else                                 w_state_d = StXfer;
        end
      end
      StWait: begin
        if (r_err)              w_state_d = StDone;
        else if (r_wcnt == 4'd0) w_state_d = StXfer;
      end
      StXfer:  if (w_last) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= StIdle;
      r_rd        <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_beat      <= 3'd0;
      r_last_beat <= 3'd0;
      r_wcnt      <= 4'd0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_rd        <= req_read_i;
        r_err       <= w_req_err;
        r_idx       <= w_idx[AW-1:0];
        r_beat      <= 3'd0;
        r_last_beat <= w_last_beat;
        r_wcnt      <= WaitLoad;
        r_wdata     <= wr_data_i;
        if (req_read_i) r_rdata <= '0;
      end
      if ((r_state == StWait) && (r_wcnt != 4'd0)) r_wcnt <= r_wcnt - 4'd1;
      if (r_state == StXfer) begin
        r_beat <= r_beat + 3'd1;
        if (r_rd) r_rdata[{r_beat, 5'b0} +: 32] <= r_mem[w_mem_addr];
      end
    end
  end

  // RAM contents survive reset; reset forces IDLE, which blocks further beats.
  always_ff @(posedge clk_i) begin
    if ((r_state == StXfer) && !r_rd) r_mem[w_mem_addr] <= w_wword;
  end

  assign rd_data_o = r_rdata;
  assign busy_o    = (r_state != StIdle);
  assign done_o    = (r_state == StDone);
  assign err_o     = (r_state == StDone) && r_err;

`ifdef CODMA_RESP_STATS_EN
  logic [15:0] r_rd_cnt, r_wr_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rd_cnt <= 16'd0;
      r_wr_cnt <= 16'd0;
    end else if ((r_state == StDone) && !r_err) begin
      if (r_rd && (r_rd_cnt != 16'hFFFF))  r_rd_cnt <= r_rd_cnt + 16'd1;
      if (!r_rd && (r_wr_cnt != 16'hFFFF)) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign rd_count_o = r_rd_cnt;
  assign wr_count_o = r_wr_cnt;
`else
  assign rd_count_o = 16'd0;
  assign wr_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_codma_mem_responder.sv
// Self-checking bench for codma_mem_responder: directed test-plan steps plus random requests
// checked against an array-based memory model.
module tb_codma_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WAITC = 2;
  localparam longint     BASE  = 0;
`ifdef CODMA_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_i;
  logic         req_read_i, req_write_i;
  logic [31:0]  req_addr_i;
  logic [7:0]   req_size_i;
  logic [255:0] wr_data_i, rd_data_o;
  logic         busy_o, done_o, err_o;
  logic [15:0]  rd_count_o, wr_count_o;

  always #5 clk = ~clk;

  codma_mem_responder #(
    .DEPTH       (DEPTH),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_read_i  (req_read_i),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_size_i  (req_size_i),
    .wr_data_i   (wr_data_i),
    .rd_data_o   (rd_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rd_count_o  (rd_count_o),
    .wr_count_o  (wr_count_o)
  );

  int           checks = 0;
  int           errors = 0;
  logic [31:0]  model [DEPTH];
  logic [255:0] last_rd = '0;
  int           exp_rd = 0;
  int           exp_wr = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(input logic [7:0] size);
    if (size == 8'd3) return 2;
    if (size == 8'd8) return 4;
    if (size == 8'd9) return 8;
    return 0;
  endfunction

  function automatic bit is_err(input logic [31:0] addr, input logic [7:0] size);
    longint a = longint'(addr);
    if (beats_of(size) == 0) return 1'b1;
    if (a % 4 != 0) return 1'b1;
    if (a < BASE) return 1'b1;
    return ((a - BASE) / 4 + beats_of(size)) > DEPTH;
  endfunction

  function automatic logic [255:0] model_read(input logic [31:0] addr, input logic [7:0] size);
    logic [255:0] d = '0;
    int idx = int'((longint'(addr) - BASE) / 4);
    for (int k = 0; k < beats_of(size); k++) d[32*k +: 32] = model[idx + k];
    return d;
  endfunction

  task automatic model_apply(input bit rd, input logic [31:0] addr, input logic [7:0] size,
                             input logic [255:0] data);
    int idx;
    if (rd) begin
      last_rd = is_err(addr, size) ? '0 : model_read(addr, size);
      if (!is_err(addr, size)) exp_rd++;
    end else if (!is_err(addr, size)) begin
      idx = int'((longint'(addr) - BASE) / 4);
      for (int k = 0; k < beats_of(size); k++) model[idx + k] = data[32*k +: 32];
      exp_wr++;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!done_o && n < 40);
  endtask

  task automatic run_req(input string tag, input bit rd, input logic [31:0] addr,
                         input logic [7:0] size, input logic [255:0] data);
    int n;
    bit e = is_err(addr, size);
    @(negedge clk);
    req_read_i = rd; req_write_i = !rd; req_addr_i = addr; req_size_i = size; wr_data_i = data;
    @(posedge clk); #1;
    req_read_i = 1'b0; req_write_i = 1'b0;
    check({tag, "_busy"}, busy_o, 1'b1);
    wait_done(n);
    check({tag, "_latency"}, n, e ? 1 : WAITC + beats_of(size));
    check({tag, "_err"}, err_o, e);
    model_apply(rd, addr, size, data);
    check({tag, "_rdata"}, rd_data_o, last_rd);
    @(posedge clk); #1;
    check({tag, "_idle"}, {busy_o, done_o, err_o}, 3'b000);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_rdcnt"}, rd_count_o, STATS ? 16'(exp_rd) : 16'd0);
    check({tag, "_wrcnt"}, wr_count_o, STATS ? 16'(exp_wr) : 16'd0);
  endtask

  initial begin
    logic [255:0] d;
    logic [31:0]  a;
    logic [7:0]   s;
    int           n;

    reset_i = 1'b1; req_read_i = 1'b0; req_write_i = 1'b0;
    req_addr_i = '0; req_size_i = '0; wr_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy_o, done_o, err_o}, 3'b000);
    check("reset_rdata", rd_data_o, '0);
    check_counts("reset");
    @(negedge clk); reset_i = 1'b0;

    // Fill the whole RAM so every later readback compares against known data.
    for (int i = 0; i < DEPTH / 8; i++) begin
      for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
      run_req("fill", 1'b0, 32'(i * 32), 8'd9, d);
    end

    for (int k = 0; k < 8; k++) d[32*k +: 32] = 32'(8'h11 * (k + 1));
    run_req("wr40", 1'b0, 32'h40, 8'd9, d);
    run_req("rd40", 1'b1, 32'h40, 8'd9, '0);
    check("rd40_value", rd_data_o, d);
    run_req("rd44_s3", 1'b1, 32'h44, 8'd3, '0);
    check("rd44_word0", rd_data_o[31:0], 32'h22);

    run_req("err_size5", 1'b1, 32'h40, 8'd5, '0);
    run_req("err_misalign", 1'b1, 32'h42, 8'd3, '0);
    run_req("err_range", 1'b1, 32'((DEPTH - 2) * 4), 8'd8, '0);
    run_req("err_wr_range", 1'b0, 32'((DEPTH - 2) * 4), 8'd8, {256{1'b1}});
    run_req("rd_tail", 1'b1, 32'((DEPTH - 4) * 4), 8'd8, '0);

    // Read and write raised together: read first, held write follows after DONE/IDLE.
    for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
    @(negedge clk);
    req_read_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h100; req_size_i = 8'd8;
    wr_data_i = d;
    @(posedge clk); #1;
    req_read_i = 1'b0;
    wait_done(n);
    check("dual_rd_latency", n, WAITC + 4);
    model_apply(1'b1, 32'h100, 8'd8, '0);
    check("dual_rd_data", rd_data_o, last_rd);
    wait_done(n);
    req_write_i = 1'b0;
    check("dual_wr_latency", n, 2 + WAITC + 4);
    check("dual_wr_err", err_o, 1'b0);
    model_apply(1'b0, 32'h100, 8'd8, d);
    check("dual_rdata_held", rd_data_o, last_rd);
    @(posedge clk); #1;
    run_req("dual_readback", 1'b1, 32'h100, 8'd8, '0);

    // Reset during beat 3 of an 8-beat write: only words 0..2 land.
    for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
    @(negedge clk);
    req_write_i = 1'b1; req_addr_i = 32'h200; req_size_i = 8'd9; wr_data_i = d;
    @(posedge clk); #1;
    req_write_i = 1'b0;
    repeat (WAITC + 3) @(posedge clk);
    #1;
    reset_i = 1'b1;
    #1;
    check("rst_mid_outputs", {busy_o, done_o, err_o}, 3'b000);
    check("rst_mid_rdata", rd_data_o, '0);
    for (int k = 0; k < 3; k++) model[128 + k] = d[32*k +: 32];
    last_rd = '0; exp_rd = 0; exp_wr = 0;
    check_counts("rst_mid");
    @(negedge clk); reset_i = 1'b0;
    run_req("rst_readback", 1'b1, 32'h200, 8'd9, '0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       s = 8'd3;
        1:       s = 8'd8;
        2:       s = 8'd9;
        default: s = 8'($urandom_range(0, 12));
      endcase
      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
      run_req("rand", 1'($urandom_range(0, 1)), a, s, d);
    end
    check_counts("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/codma_mem_responder.md
# codma_mem_responder

Memory-side responder for the CODMA read/write request interface: accepts single burst read or write requests from the DMA machine, services them one 32-bit word per cycle against an internal word-addressed RAM after a programmable wait, and signals completion with a one-cycle done pulse. It sits opposite the DMA controller's request/data ports and serves as both the system scratch memory and the bench memory model for DMA task lists and payloads.

## Interface
Parameters:
- DEPTH, 1024: RAM depth in 32-bit words (power of two, ≥ 8).
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word aligned.
- WAIT_CYCLES, 2: cycles between accept and first beat, 0..15.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- req_read_i  in  1  read request, level, sampled only in IDLE.
- req_write_i  in  1  write request, level, sampled only in IDLE.
- req_addr_i  in  32  byte start address.
- req_size_i  in  8  burst size code: 3 = 2 words (8 B), 8 = 4 words (16 B), 9 = 8 words (32 B).
- wr_data_i  in  8x32  write payload; word k goes to address + 4k.
- rd_data_o  out  8x32  read payload, word k from address + 4k.
- busy_o  out  1  request in service.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  qualifies done_o: request rejected.
- rd_count_o  out  16  completed good reads (stats).
- wr_count_o  out  16  completed good writes (stats).

## Operation
- States: IDLE, WAIT, XFER, DONE.
- IDLE: if req_read_i or req_write_i high at an edge → accept. Read has priority when both are high; the write stays pending and is accepted after the read completes if still held.
- On accept: latch direction, addr, size, wr_data_i; clear rd_data_o to zero on reads; load beat count (2/4/8) and wait counter.
- Checks at accept, any failure → DONE with err_o=1, no RAM access, WAIT/XFER skipped: size code not in {3,8,9}; addr[1:0] ≠ 0; addr < BASE_ADDR; word index + beats > DEPTH.
- WAIT: count down WAIT_CYCLES; when 0 → XFER. With WAIT_CYCLES=0, accept goes straight to XFER.
- XFER: one word per cycle, beat k at word index + k; reads write rd_data_o[k], writes update RAM. After last beat → DONE.
- DONE: done_o=1 one cycle, err_o valid; next edge → IDLE.
- rd_data_o holds its value until the next read is accepted; writes never change it.
- Index arithmetic: word index = (addr − BASE_ADDR) >> 2, 32-bit unsigned; range check done before any beat, no wrap.
- Reset (any time, incl. mid-burst): state IDLE, busy_o=0, done_o=0, err_o=0, rd_data_o=0, counters=0; partial write bursts remain partially applied; RAM is not cleared.

## Timing
- Accept edge = edge 0. busy_o high from edge 0 through the DONE cycle, low after the edge leaving DONE.
- Good request: done_o high for the cycle following edge WAIT_CYCLES + beats; e.g. WAIT=2, size 9 → done_o after edge 10.
- Error request: done_o and err_o high for the cycle following edge 1.
- rd_data_o final when done_o is high.
- Earliest next accept: the edge ending DONE is IDLE→ no; the first edge in which state is IDLE, i.e. one cycle after done_o. A request held through done_o is re-accepted as a new request.

## Configuration
- CODMA_RESP_STATS_EN defined: rd_count_o/wr_count_o increment at DONE for non-error reads/writes; saturate at 16'hFFFF.
- Not defined: counters not implemented, rd_count_o and wr_count_o tied to 0.

## Test plan
- Write size 9 at 0x40 data words 0x11..0x88, WAIT=2 → done_o after edge 10, err_o=0; read size 9 at 0x40 → rd_data_o = 0x11..0x88.
- Read size 3 at 0x44 after above → rd_data_o[0]=0x22, [1]=0x33, words 2..7 = 0; done_o after edge 4.
- Read size 5, then read at 0x42, then read at (DEPTH−2)*4 size 8 → each done_o+err_o after edge 1, rd_data_o=0, RAM unchanged.
- req_read_i and req_write_i high together, held → read serviced first, write accepted one cycle after read done_o.
- Assert reset_i during beat 3 of size-9 write → busy_o, done_o, rd_data_o go 0 immediately; readback shows words 0..2 new, 3..7 old.
- With CODMA_RESP_STATS_EN: 3 good reads, 2 good writes, 1 error → rd_count_o=3, wr_count_o=2; without macro both read 0.
